// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-wide RAM controller shared by instruction fetch
// (IF) and the memory-access stage (MA). Each 8/16/32-bit request is split
// into little-endian byte cycles. Loads return sign- or zero-extended data.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready; low freezes the controller and the RAM
//   if_re/if_addr       IF word fetch request
//   if_rdata/if_busy    fetched word / IF stall
//   ma_re/ma_we         MA load / store request (store wins)
//   ma_width            000 B, 001 H, 010 W, 100 BU, 101 HU, others W
//   ma_addr/ma_wdata    MA byte address / store data
//   ma_rdata/ma_busy    extended load data / MA stall
//   mem_din             RAM read data, one cycle after its address
//   mem_dout/mem_a      RAM write data / byte address
//   mem_wr              RAM write strobe
module mem_ctrl #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_re,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_busy,
    input  logic              ma_re,
    input  logic              ma_we,
    input  logic [2:0]        ma_width,
    input  logic [31:0]       ma_addr,
    input  logic [31:0]       ma_wdata,
    output logic [31:0]       ma_rdata,
    output logic              ma_busy,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_MA = 1'b1;

    // Index of the final byte of a transfer (transfer length minus one).
    function automatic logic [1:0] last_idx(input logic [2:0] w);
        case (w)
            W_B, W_BU: last_idx = 2'd0;
            W_H, W_HU: last_idx = 2'd1;
            default:   last_idx = 2'd3;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [2:0]          width_q, width_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         ma_rdata_q, ma_rdata_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_wr_q, mem_wr_d;

    logic                ma_req;
    logic [1:0]          last_q;
    logic                is_last;
    logic                cap_en;
    logic [1:0]          cap_idx;
    logic [31:0]         cap_word;
    logic                unused_addr_hi;

    assign ma_req  = ma_re | ma_we;
    assign last_q  = last_idx(width_q);
    assign is_last = (cnt_q == last_q);

    // Only the low ADDR_W address bits reach the RAM.
    assign unused_addr_hi = ^{if_addr[31:ADDR_W], ma_addr[31:ADDR_W]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rdy low freezes the sequence.
    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                S_IDLE:   if (ma_req || if_re) state_d = S_ACCESS;
                S_ACCESS: if (is_last)         state_d = we_q ? S_DONE : S_WAIT;
                S_WAIT:   state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Read byte arriving this cycle belongs to the address issued last cycle.
    always_comb begin
        cap_en  = !we_q && ((state_q == S_ACCESS && cnt_q != 2'd0) || state_q == S_WAIT);
        cap_idx = (state_q == S_WAIT) ? last_q : (cnt_q - 2'd1);
    end

    // Owner's rdata with the incoming byte merged; the final byte applies extension.
    always_comb begin
        cap_word = (owner_q == OWN_MA) ? ma_rdata_q : if_rdata_q;
        cap_word[{cap_idx, 3'b000} +: 8] = mem_din;
        if (state_q == S_WAIT) begin
            case (width_q)
                W_B:     cap_word = {{24{mem_din[7]}}, mem_din};
                W_BU:    cap_word = {24'd0, mem_din};
                W_H:     cap_word = {{16{mem_din[7]}}, cap_word[15:0]};
                W_HU:    cap_word = {16'd0, cap_word[15:0]};
                default: cap_word = cap_word;
            endcase
        end
    end

    // Output / datapath next values: request latch, byte counter, RAM port, rdata.
    always_comb begin
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        width_d    = width_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ma_rdata_d = ma_rdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;

        if (rdy) begin
            if (state_q == S_IDLE) begin
                // MA has fixed priority over IF.
                if (ma_req) begin
                    owner_d = OWN_MA;
                    we_d    = ma_we;
                    width_d = ma_width;
                    addr_d  = ma_addr[ADDR_W-1:0];
                    wdata_d = ma_wdata;
                    cnt_d   = 2'd0;
                end else if (if_re) begin
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    width_d = W_W;
                    addr_d  = if_addr[ADDR_W-1:0];
                    cnt_d   = 2'd0;
                end
            end else if (state_q == S_ACCESS && !is_last) begin
                cnt_d = cnt_q + 2'd1;
            end

            if (cap_en) begin
                if (owner_q == OWN_MA) begin
                    ma_rdata_d = cap_word;
                end else begin
                    if_rdata_d = cap_word;
                end
            end

            // RAM port is registered: present next cycle's byte address/data now.
            mem_wr_d = (state_d == S_ACCESS) && we_d;
            if (state_d == S_ACCESS) begin
                mem_a_d    = addr_d + ADDR_W'(cnt_d);
                mem_dout_d = wdata_d[{cnt_d, 3'b000} +: 8];
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 2'd0;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            width_q    <= W_W;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            ma_rdata_q <= 32'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            width_q    <= width_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ma_rdata_q <= ma_rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    // Strobe is held across a stall but must never reach the RAM while rdy is low.
    assign mem_wr   = mem_wr_q & rdy;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign if_rdata = if_rdata_q;
    assign ma_rdata = ma_rdata_q;

    // A requester stalls until the DONE cycle of its own transaction.
    assign if_busy = !rst && if_re  && !(state_q == S_DONE && owner_q == OWN_IF);
    assign ma_busy = !rst && ma_req && !(state_q == S_DONE && owner_q == OWN_MA);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a byte-array RAM model and
// a byte-level reference memory used to predict load data and RAM writes.
module tb_mem_ctrl;

    localparam int unsigned AW    = 17;
    localparam int          MEM_N = 1 << AW;
    localparam int          TXN_MAX = 200;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic          if_re;
    logic [31:0]   if_addr, if_rdata;
    logic          if_busy;
    logic          ma_re, ma_we;
    logic [2:0]    ma_width;
    logic [31:0]   ma_addr, ma_wdata, ma_rdata;
    logic          ma_busy;
    logic [7:0]    mem_din, mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .if_re    (if_re),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_busy  (if_busy),
        .ma_re    (ma_re),
        .ma_we    (ma_we),
        .ma_width (ma_width),
        .ma_addr  (ma_addr),
        .ma_wdata (ma_wdata),
        .ma_rdata (ma_rdata),
        .ma_busy  (ma_busy),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr)
    );

    always #5 clk = ~clk;

    // Synchronous RAM stalled by rdy, read data one cycle after address.
    logic [7:0] ram [0:MEM_N-1];
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) ram[mem_a] <= mem_dout;
            mem_din <= ram[mem_a];
        end
    end

    // Reference state.
    logic [7:0]  ref_mem [0:MEM_N-1];
    logic [31:0] if_q[$];
    logic [31:0] ma_q[$];
    logic [24:0] exp_wr_q[$];
    logic [31:0] ma_last;
    logic [AW-1:0] alog [0:15];

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  rdy_rand = 1'b0;
    int  stall_lo = 0;
    int  stall_len = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int len_of(input logic [2:0] w);
        case (w)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int wrap_idx(input logic [31:0] a, input int k);
        return (int'(a[AW-1:0]) + k) % MEM_N;
    endfunction

    task automatic model_load(input logic [31:0] a, input logic [2:0] w, output logic [31:0] v);
        int n;
        n = len_of(w);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[wrap_idx(a, k)]) << (8 * k));
        if (w == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (w == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    endtask

    task automatic model_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
        int n;
        logic [31:0] sh;
        n = len_of(w);
        for (int k = 0; k < n; k++) begin
            sh = d >> (8 * k);
            ref_mem[wrap_idx(a, k)] = sh[7:0];
            exp_wr_q.push_back({17'(wrap_idx(a, k)), sh[7:0]});
        end
    endtask

    function automatic bit rdy_at(input int k);
        if (k >= stall_lo && k < stall_lo + stall_len) return 1'b0;
        if (rdy_rand) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    // Monitor: RAM writes against expected byte stream, completions against scoreboard.
    always @(negedge clk) begin
        logic [24:0] e;
        if (!rst && mon_en) begin
            if (!rdy) chk("wr_while_stalled", 32'(mem_wr), 32'd0);
            if (mem_wr) begin
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_write_addr", 32'(mem_a), 32'hFFFF_FFFF);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", 32'(mem_a), 32'(e[24:8]));
                    chk("wr_data", 32'(mem_dout), 32'(e[7:0]));
                end
            end
            if (if_re && rdy && !if_busy) begin
                if (if_q.size() == 0) chk("if_unexpected_done", if_rdata, 32'hDEAD_0000);
                else chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if ((ma_re || ma_we) && rdy && !ma_busy) begin
                if (ma_q.size() == 0) chk("ma_unexpected_done", ma_rdata, 32'hDEAD_0001);
                else chk("ma_rdata", ma_rdata, ma_q.pop_front());
            end
        end
    end

    // Issue MA and/or IF request, hold until each sees busy low, return latencies from T0.
    task automatic txn(input bit mg, input bit mwe, input logic [2:0] mw, input logic [31:0] ma,
                       input logic [31:0] md, input bit ig, input logic [31:0] ia,
                       output int mlat, output int ilat);
        bit mp, ip;
        int k;
        logic [31:0] v;
        mp = mg; ip = ig; k = 0; mlat = -1; ilat = -1;
        if (mg) begin
            if (mwe) begin
                model_store(ma, mw, md);
                ma_q.push_back(ma_last);
            end else begin
                model_load(ma, mw, v);
                ma_last = v;
                ma_q.push_back(v);
            end
        end
        if (ig) begin
            model_load(ia, 3'b010, v);
            if_q.push_back(v);
        end
        ma_re = mg && !mwe; ma_we = mg && mwe;
        ma_width = mw; ma_addr = ma; ma_wdata = md;
        if_re = ig; if_addr = ia;
        rdy = rdy_at(0);
        while ((mp || ip) && k < TXN_MAX) begin
            @(negedge clk);
            if (k < 16) alog[k] = mem_a;
            if (mp && rdy && !ma_busy) begin mlat = k; mp = 1'b0; end
            if (ip && rdy && !if_busy) begin ilat = k; ip = 1'b0; end
            @(posedge clk); #1;
            k++;
            if (!mp) begin ma_re = 1'b0; ma_we = 1'b0; end
            if (!ip) if_re = 1'b0;
            // Fields were latched at T0; changing them now must not matter.
            if (mp && !rdy_rand && stall_len == 0) begin
                ma_width = 3'($urandom); ma_addr = $urandom; ma_wdata = $urandom;
            end
            if (ip && !mg && !rdy_rand && stall_len == 0) if_addr = $urandom;
            rdy = rdy_at(k);
        end
        if (mp || ip) begin
            chk("txn_timeout", 32'(k), 32'(TXN_MAX + 1));
            ma_re = 1'b0; ma_we = 1'b0; if_re = 1'b0;
        end
        rdy = 1'b1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] r;
        logic [AW-1:0] lo;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) lo = AW'(32'h1FFFC + $urandom_range(0, 3));
        else lo = AW'(32'h0F0 + $urandom_range(0, 287));
        return {r[31:AW], lo};
    endfunction

    initial begin
        int ml, il, sel, n;
        logic [2:0] w;
        bit we;

        rst = 1'b1; rdy = 1'b1;
        if_re = 1'b1; if_addr = 32'd0;
        ma_re = 1'b1; ma_we = 1'b0; ma_width = 3'b010; ma_addr = 32'd0; ma_wdata = 32'd0;
        ma_last = 32'd0;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = 8'd0;

        // Reset state, busy suppressed while rst even with requests high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_busy", 32'(if_busy), 32'd0);
        chk("rst_ma_busy", 32'(ma_busy), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_a", 32'(mem_a), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ma_rdata", ma_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; if_re = 1'b0; ma_re = 1'b0; mon_en = 1'b1;
        @(posedge clk); #1;

        // Word store, byte store into its top byte, read back.
        txn(1, 1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 0, 0, ml, il);
        chk("sw_lat", 32'(ml), 32'd5);
        for (int k = 1; k <= 4; k++) chk("sw_mem_a", 32'(alog[k]), 32'h200 + 32'(k - 1));
        txn(1, 1, 3'b000, 32'h0000_0203, 32'h1234_565A, 0, 0, ml, il);
        chk("sb_lat", 32'(ml), 32'd2);
        txn(1, 0, 3'b010, 32'h0000_0200, 0, 0, 0, ml, il);
        chk("lw_lat", 32'(ml), 32'd6);
        chk("lw_after_sb", ma_rdata, 32'h5AAD_BEEF);

        // IF fetch of 11 22 33 44.
        txn(1, 1, 3'b000, 32'h100, 32'h11, 0, 0, ml, il);
        txn(1, 1, 3'b000, 32'h101, 32'h22, 0, 0, ml, il);
        txn(1, 1, 3'b000, 32'h102, 32'h33, 0, 0, ml, il);
        txn(1, 1, 3'b000, 32'h103, 32'h44, 0, 0, ml, il);
        txn(0, 0, 3'b000, 0, 0, 1, 32'h0000_0100, ml, il);
        chk("if_lat", 32'(il), 32'd6);
        for (int k = 1; k <= 4; k++) chk("if_mem_a", 32'(alog[k]), 32'h100 + 32'(k - 1));
        chk("if_word", if_rdata, 32'h4433_2211);

        // Signed / unsigned narrow loads.
        txn(1, 1, 3'b001, 32'h40, 32'h8080, 0, 0, ml, il);
        txn(1, 0, 3'b000, 32'h40, 0, 0, 0, ml, il);
        chk("lb_lat", 32'(ml), 32'd3);
        chk("lb_val", ma_rdata, 32'hFFFF_FF80);
        txn(1, 0, 3'b100, 32'h40, 0, 0, 0, ml, il);
        chk("lbu_lat", 32'(ml), 32'd3);
        chk("lbu_val", ma_rdata, 32'h0000_0080);
        txn(1, 0, 3'b001, 32'h40, 0, 0, 0, ml, il);
        chk("lh_lat", 32'(ml), 32'd4);
        chk("lh_val", ma_rdata, 32'hFFFF_8080);
        txn(1, 0, 3'b101, 32'h40, 0, 0, 0, ml, il);
        chk("lhu_val", ma_rdata, 32'h0000_8080);

        // Simultaneous requests: MA first, IF waits.
        txn(1, 0, 3'b010, 32'h100, 0, 1, 32'h200, ml, il);
        chk("pair_ma_lat", 32'(ml), 32'd6);
        chk("pair_if_lat", 32'(il), 32'd13);
        chk("pair_ma_val", ma_rdata, 32'h4433_2211);
        chk("pair_if_val", if_rdata, 32'h5AAD_BEEF);

        // rdy low for three cycles from T2 of a word store.
        stall_lo = 2; stall_len = 3;
        txn(1, 1, 3'b010, 32'h300, 32'hA1B2_C3D4, 0, 0, ml, il);
        stall_len = 0;
        chk("stall_sw_lat", 32'(ml), 32'd8);

        // Reset at T2 of a word load.
        ma_re = 1'b1; ma_we = 1'b0; ma_width = 3'b010; ma_addr = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(ma_busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ma_re = 1'b0;
        ma_last = 32'd0;
        @(negedge clk);
        chk("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mid_ma_rdata", ma_rdata, 32'd0);
        chk("rst_mid_if_rdata", if_rdata, 32'd0);
        @(posedge clk); #1;
        txn(1, 0, 3'b010, 32'h200, 0, 0, 0, ml, il);
        chk("rst_relw_lat", 32'(ml), 32'd6);

        // Randomised traffic; second half with random rdy stalls.
        for (int i = 0; i < 120; i++) begin
            rdy_rand = (i >= 60);
            sel = $urandom_range(0, 2);
            we = ($urandom_range(0, 1) == 1);
            w = 3'($urandom);
            n = len_of(w);
            txn(sel != 1, we, w, rnd_addr(), $urandom, sel != 0, rnd_addr(), ml, il);
            if (!rdy_rand) begin
                if (sel != 1) chk("rnd_ma_lat", 32'(ml), 32'(we ? n + 1 : n + 2));
                if (sel == 1) chk("rnd_if_lat", 32'(il), 32'd6);
                if (sel == 2) chk("rnd_if_wait_lat", 32'(il), 32'(ml + 7));
            end
        end
        rdy_rand = 1'b0;

        repeat (3) @(posedge clk);
        chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        chk("if_queue_drained", 32'(if_q.size()), 32'd0);
        chk("ma_queue_drained", 32'(ma_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
